// File: rtl/turn_seq_if.sv
// Handshake and tracker bundle between the navigation FSM / tracker sampler
// and the turn sequencer.
interface turn_seq_if #(
    parameter int SENSORS = 3,
    parameter int CNT_W   = 2
);
    logic               start;
    logic               dir;
    logic [CNT_W-1:0]   count;
    logic               abort;
    logic [SENSORS-1:0] detect;
    logic               busy;
    logic               turn_dir;
    logic               done;
    logic               error;
    logic [CNT_W-1:0]   crossings;

    modport master (
        output start, dir, count, abort, detect,
        input  busy, turn_dir, done, error, crossings
    );

    modport slave (
        input  start, dir, count, abort, detect,
        output busy, turn_dir, done, error, crossings
    );
endinterface

// File: rtl/turn_seq_ctrl.sv
// Turn sequencer: counts debounced line crossings during a left/right turn,
// pulses done after the requested count, flags a sticky error on timeout.
module turn_seq_ctrl #(
    parameter int SENSORS  = 3,
    parameter int CNT_W    = 2,
    parameter int DEBOUNCE = 2,
    parameter int TIMEOUT  = 50000,
    parameter int TO_W     = 16
) (
    input logic      clk,
    input logic      rst_n,
    turn_seq_if.slave bus
);
    localparam int RUN_W = $clog2(DEBOUNCE + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEAVE = 2'd1;
    localparam logic [1:0] S_SEEK  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cross_q, cross_d;
    logic             err_q, err_d;
    logic             armed_q, armed_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic [RUN_W-1:0] on_run_q, on_run_d;
    logic [RUN_W-1:0] off_run_q, off_run_d;

    logic             all_on;
    logic             on_hit;
    logic             off_hit;
    logic             complete;
    logic [CNT_W-1:0] cross_inc;

    assign all_on = (bus.detect == {SENSORS{1'b1}});

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        on_run_d  = '0;
        off_run_d = '0;
        if (all_on) begin
            on_run_d = (on_run_q == RUN_MAX) ? on_run_q : on_run_q + 1'b1;
        end else begin
            off_run_d = (off_run_q == RUN_MAX) ? off_run_q : off_run_q + 1'b1;
        end
    end

    assign on_hit    = (on_run_d == RUN_MAX);
    assign off_hit   = (off_run_d == RUN_MAX);
    assign cross_inc = (cross_q == CNT_MAX) ? cross_q : cross_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        target_d = target_q;
        cross_d  = cross_q;
        err_d    = err_q;
        armed_d  = armed_q;
        timer_d  = timer_q;
        complete = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dir_d    = bus.dir;
                    target_d = (bus.count == '0) ? CNT_W'(1) : bus.count;
                    cross_d  = '0;
                    timer_d  = '0;
                    err_d    = 1'b0;
                    armed_d  = 1'b0;
                    state_d  = S_LEAVE;
                end
            end
            S_LEAVE, S_SEEK: begin
                // Abort outranks completion, which outranks timeout.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (state_q == S_LEAVE) begin
                        if (off_hit) begin
                            state_d = S_SEEK;
                            armed_d = 1'b1;
                        end
                    end else if (armed_q && on_hit) begin
                        cross_d  = cross_inc;
                        armed_d  = 1'b0;
                        complete = (cross_inc >= target_q);
                    end else if (off_hit) begin
                        armed_d = 1'b1;
                    end

                    if (complete) begin
                        state_d = S_DONE;
                    end else if (timer_d == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; next-state logic above is blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            target_q  <= '0;
            cross_q   <= '0;
            err_q     <= 1'b0;
            armed_q   <= 1'b0;
            timer_q   <= '0;
            on_run_q  <= '0;
            off_run_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            target_q  <= target_d;
            cross_q   <= cross_d;
            err_q     <= err_d;
            armed_q   <= armed_d;
            timer_q   <= timer_d;
            on_run_q  <= on_run_d;
            off_run_q <= off_run_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.turn_dir  = dir_q;
    assign bus.error     = err_q;
    assign bus.crossings = cross_q;
endmodule

// File: tb/tb_turn_seq_ctrl.sv
// Bench for turn_seq_ctrl: directed scenarios plus randomized traffic, all
// compared every cycle against a sample-history reference model.
module tb_turn_seq_ctrl;
    localparam int SENSORS  = 3;
    localparam int CNT_W    = 2;
    localparam int DEBOUNCE = 2;
    localparam int TIMEOUT  = 20;
    localparam int TO_W     = 5;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_LEAVE = 1;
    localparam int P_SEEK  = 2;
    localparam int P_DONE  = 3;

    localparam logic [SENSORS-1:0] ON  = '1;
    localparam logic [SENSORS-1:0] OFF = '0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    turn_seq_if #(.SENSORS(SENSORS), .CNT_W(CNT_W)) bus();

    turn_seq_ctrl #(
        .SENSORS(SENSORS), .CNT_W(CNT_W), .DEBOUNCE(DEBOUNCE),
        .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: phase of the turn, elapsed cycles and the recent sample history.
    int m_phase;
    bit m_dir;
    int m_target;
    int m_cross;
    int m_elapsed;
    bit m_err;
    bit m_armed;
    bit hist[$];

    function automatic void model_reset();
        m_phase = P_IDLE; m_dir = 0; m_target = 0; m_cross = 0;
        m_elapsed = 0; m_err = 0; m_armed = 0;
        hist.delete();
    endfunction

    function automatic bit last_all(input bit v);
        if (hist.size() < DEBOUNCE) return 0;
        foreach (hist[i]) if (hist[i] != v) return 0;
        return 1;
    endfunction

    function automatic void model_step(input bit st, input bit d, input int cnt,
                                       input bit ab, input logic [SENSORS-1:0] det);
        bit on_ok, off_ok, completed;
        int c;
        hist.push_back(det == ON);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        on_ok  = last_all(1'b1);
        off_ok = last_all(1'b0);
        completed = 0;
        if (m_phase == P_IDLE) begin
            if (st) begin
                c = cnt % (1 << CNT_W);
                m_dir = d; m_target = (c == 0) ? 1 : c;
                m_cross = 0; m_elapsed = 0; m_err = 0; m_armed = 0;
                m_phase = P_LEAVE;
            end
        end else if (ab || m_phase == P_DONE) begin
            m_phase = P_IDLE;
        end else begin
            m_elapsed++;
            if (m_phase == P_LEAVE) begin
                if (off_ok) begin m_phase = P_SEEK; m_armed = 1; end
            end else if (m_armed && on_ok) begin
                m_cross = (m_cross < CNT_SAT) ? m_cross + 1 : CNT_SAT;
                m_armed = 0;
                completed = (m_cross >= m_target);
            end else if (off_ok) begin
                m_armed = 1;
            end
            if (completed) m_phase = P_DONE;
            else if (m_elapsed == TIMEOUT - 1) begin m_err = 1; m_phase = P_IDLE; end
        end
    endfunction

    task automatic check_all(input string p);
        check({p, ".busy"},      bus.busy,      m_phase != P_IDLE);
        check({p, ".done"},      bus.done,      m_phase == P_DONE);
        check({p, ".error"},     bus.error,     m_err);
        check({p, ".crossings"}, bus.crossings, m_cross);
        check({p, ".turn_dir"},  bus.turn_dir,  m_dir);
    endtask

    // Drives one cycle from a negedge, steps the model at the posedge, checks 1 time unit later.
    task automatic cyc(input bit st, input bit d, input int cnt, input bit ab,
                       input logic [SENSORS-1:0] det);
        bus.start = st; bus.dir = d; bus.count = CNT_W'(cnt); bus.abort = ab; bus.detect = det;
        @(posedge clk);
        model_step(st, d, cnt, ab, det);
        #1 check_all("cyc");
        @(negedge clk);
    endtask

    task automatic idle(input logic [SENSORS-1:0] det);
        cyc(0, 0, 0, 0, det);
    endtask

    task automatic do_reset(input string p);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all(p);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [SENSORS-1:0] pick_detect();
        int r = $urandom_range(0, 9);
        if (r < 4) return ON;
        if (r < 8) return OFF;
        return SENSORS'($urandom);
    endfunction

    initial begin
        logic [SENSORS-1:0] det;
        rst_n = 1'b0;
        bus.start = 0; bus.dir = 0; bus.count = '0; bus.abort = 0; bus.detect = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all("reset");
        check("reset.busy_const", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: two crossings, left turn
        cyc(1, 0, 2, 0, ON);
        idle(ON); idle(ON);
        idle(3'b010); idle(3'b010);
        idle(ON); idle(ON);
        check("t1.cross1", bus.crossings, 1);
        check("t1.nodone1", bus.done, 0);
        idle(OFF); idle(OFF);
        idle(ON); idle(ON);
        check("t1.cross2", bus.crossings, 2);
        check("t1.done", bus.done, 1);
        check("t1.dir", bus.turn_dir, 0);
        check("t1.err", bus.error, 0);
        idle(ON);
        check("t1.done_end", bus.done, 0);
        check("t1.busy_end", bus.busy, 0);

        // 2: count 0 behaves as 1, right turn
        cyc(1, 1, 0, 0, OFF);
        idle(OFF); idle(ON); idle(ON);
        check("t2.done", bus.done, 1);
        check("t2.cross", bus.crossings, 1);
        check("t2.dir", bus.turn_dir, 1);
        idle(ON);

        // 3: one-cycle glitch in SEEK
        cyc(1, 0, 1, 0, OFF);
        idle(OFF); idle(ON); idle(OFF); idle(OFF);
        check("t3.cross", bus.crossings, 0);
        check("t3.busy", bus.busy, 1);
        cyc(0, 0, 0, 1, OFF);

        // 4: timeout with detect held off-line
        cyc(1, 0, 2, 0, OFF);
        for (int i = 1; i < TIMEOUT - 1; i++) idle(OFF);
        check("t4.busy_pre", bus.busy, 1);
        check("t4.err_pre", bus.error, 0);
        idle(OFF);
        check("t4.err", bus.error, 1);
        check("t4.busy", bus.busy, 0);
        idle(OFF);
        check("t4.sticky", bus.error, 1);
        cyc(1, 0, 1, 0, OFF);
        check("t4.clear", bus.error, 0);
        cyc(0, 0, 0, 1, OFF);

        // 5: abort on the final-crossing edge
        cyc(1, 0, 1, 0, OFF);
        idle(OFF); idle(ON);
        cyc(0, 0, 0, 1, ON);
        check("t5.cross", bus.crossings, 0);
        check("t5.busy", bus.busy, 0);
        check("t5.done", bus.done, 0);
        idle(ON);

        // 6: start while busy is ignored; async reset mid-SEEK
        cyc(1, 0, 1, 0, OFF);
        cyc(1, 1, 3, 0, OFF);
        check("t6.dir_kept", bus.turn_dir, 0);
        idle(ON); idle(ON);
        check("t6.target_kept", bus.done, 1);
        idle(OFF);
        cyc(1, 1, 3, 0, OFF);
        idle(OFF); idle(ON); idle(ON);
        check("t6.cross_pre", bus.crossings, 1);
        do_reset("t6.rst");
        check("t6.busy_rst", bus.busy, 0);
        check("t6.cross_rst", bus.crossings, 0);

        // Randomized traffic
        det = OFF;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd.rst");
            end else begin
                if ($urandom_range(0, 2) == 0) det = pick_detect();
                cyc($urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 39) == 0, det);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
